// File: rtl/gray_stream_checker_pkg.sv
// rtl/gray_stream_checker_pkg.sv - shared types, defaults and helpers for the Gray stream checker
package gray_stream_checker_pkg;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_SYNCED = 2'd1,
        ST_LOST   = 2'd2
    } link_state_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_stream_checker_gray2bin.sv
// rtl/gray_stream_checker_gray2bin.sv - combinational Gray-to-binary decoder
module gray2bin_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/gray_stream_checker.sv
// rtl/gray_stream_checker.sv - decodes a Gray stream and checks single-bit step legality
module gray_stream_checker
    import gray_stream_checker_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_gray,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_binary,
    output logic                 out_step_err,
    output logic                 out_dir_up,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 sync_lost
);

    link_state_e          state_q, state_d;
    logic [WIDTH-1:0]     prev_gray_q, prev_gray_d;
    logic                 consec_q, consec_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_binary_q, out_binary_d;
    logic                 out_step_err_q, out_step_err_d;
    logic                 out_dir_up_q, out_dir_up_d;

    logic [WIDTH-1:0]     in_bin;
    logic [WIDTH-1:0]     prev_bin;
    logic [WIDTH-1:0]     prev_inc;
    logic                 accept;
    logic                 step_ok;
    logic                 step_up;

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec_in (
        .gray_i (in_gray),
        .bin_o  (in_bin)
    );

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec_prev (
        .gray_i (prev_gray_q),
        .bin_o  (prev_bin)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign prev_inc = prev_bin + WIDTH'(1);
    assign step_ok  = (popcount(32'(in_gray ^ prev_gray_q)) == 1);
    assign step_up  = (in_bin == prev_inc);

    always_comb begin
        state_d        = state_q;
        prev_gray_d    = prev_gray_q;
        consec_d       = consec_q;
        err_cnt_d      = err_cnt_q;
        out_valid_d    = out_valid_q;
        out_binary_d   = out_binary_q;
        out_step_err_d = out_step_err_q;
        out_dir_up_d   = out_dir_up_q;

        if (accept) begin
            out_valid_d    = 1'b1;
            prev_gray_d    = in_gray;
            out_binary_d   = in_bin;
            out_dir_up_d   = step_up;
            out_step_err_d = 1'b0;
            case (state_q)
                ST_UNSYNC: state_d = ST_SYNCED;
                ST_SYNCED: begin
                    if (step_ok) begin
                        consec_d = 1'b0;
                    end else begin
                        out_step_err_d = 1'b1;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                        if (consec_q) begin
                            state_d  = ST_LOST;
                            consec_d = 1'b0;
                        end else begin
                            consec_d = 1'b1;
                        end
                    end
                end
                ST_LOST: begin
                    if (step_ok) begin
                        state_d = ST_SYNCED;
                    end
                end
                default: state_d = ST_UNSYNC;
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear overrides the FSM; an accepted sample in the same cycle becomes the new seed.
        if (clear) begin
            err_cnt_d = '0;
            consec_d  = 1'b0;
            if (accept) begin
                out_step_err_d = 1'b0;
                state_d        = ST_SYNCED;
            end else begin
                state_d = ST_UNSYNC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_UNSYNC;
            prev_gray_q    <= '0;
            consec_q       <= 1'b0;
            err_cnt_q      <= '0;
            out_valid_q    <= 1'b0;
            out_binary_q   <= '0;
            out_step_err_q <= 1'b0;
            out_dir_up_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_gray_q    <= prev_gray_d;
            consec_q       <= consec_d;
            err_cnt_q      <= err_cnt_d;
            out_valid_q    <= out_valid_d;
            out_binary_q   <= out_binary_d;
            out_step_err_q <= out_step_err_d;
            out_dir_up_q   <= out_dir_up_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_binary   = out_binary_q;
    assign out_step_err = out_step_err_q;
    assign out_dir_up   = out_dir_up_q;
    assign err_count    = err_cnt_q;
    assign sync_lost    = (state_q == ST_LOST);

endmodule

// File: tb/tb_gray_stream_checker.sv
// tb/tb_gray_stream_checker.sv - directed self-checking bench for gray_stream_checker
module tb_gray_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_gray;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_binary;
    logic       out_step_err;
    logic       out_dir_up;
    logic [1:0] err_count;
    logic       sync_lost;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int hs_base;

    always #5 clk = ~clk;

    gray_stream_checker #(.WIDTH(4), .ERR_CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_gray      (in_gray),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_binary   (out_binary),
        .out_step_err (out_step_err),
        .out_dir_up   (out_dir_up),
        .err_count    (err_count),
        .sync_lost    (sync_lost)
    );

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ed: 0/1 expected direction, 2 = don't care (direction undefined on a step error)
    task automatic send(input string tag, input logic [3:0] g, input logic [3:0] eb,
                        input logic ee, input int ed, input logic [1:0] ec, input logic el);
        in_valid = 1'b1;
        in_gray  = g;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".bin"}, out_binary, eb);
        chk({tag, ".err"}, out_step_err, ee);
        if (ed != 2) chk({tag, ".dir"}, out_dir_up, ed[0]);
        chk({tag, ".cnt"}, err_count, ec);
        chk({tag, ".lost"}, sync_lost, el);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_gray   = 4'b0000;
        out_ready = 1'b1;
        #2;
        chk("rst.valid", out_valid, 0);
        chk("rst.bin", out_binary, 0);
        chk("rst.err", out_step_err, 0);
        chk("rst.dir", out_dir_up, 0);
        chk("rst.cnt", err_count, 0);
        chk("rst.lost", sync_lost, 0);
        chk("rst.ready", in_ready, 1);
        do_reset();

        // basic counting sequence
        send("t1a", 4'b0000, 4'd0, 0, 0, 2'd0, 0);
        send("t1b", 4'b0001, 4'd1, 0, 1, 2'd0, 0);
        send("t1c", 4'b0011, 4'd2, 0, 1, 2'd0, 0);
        send("t1d", 4'b0010, 4'd3, 0, 1, 2'd0, 0);

        // 3 -> 15 jump, legal wrap 15 -> 0, repeated code, then legal step
        send("t2a", 4'b1000, 4'd15, 1, 2, 2'd1, 0);
        send("t2b", 4'b0000, 4'd0,  0, 1, 2'd1, 0);
        send("t2c", 4'b0000, 4'd0,  1, 2, 2'd2, 0);
        send("t2d", 4'b0001, 4'd1,  0, 1, 2'd2, 0);

        // two consecutive bad steps lose sync; a legal step regains it
        do_reset();
        send("t3a", 4'b0000, 4'd0,  0, 0, 2'd0, 0);
        send("t3b", 4'b0101, 4'd6,  1, 2, 2'd1, 0);
        send("t3c", 4'b1111, 4'd10, 1, 2, 2'd2, 1);
        send("t3d", 4'b1110, 4'd11, 0, 1, 2'd2, 0);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_gray   = 4'b0000;
        @(posedge clk);
        #1;
        chk("t4.first_valid", out_valid, 1);
        chk("t4.first_bin", out_binary, 0);
        in_gray = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            chk("t4.stall_ready", in_ready, 0);
            @(posedge clk);
            #1;
            chk("t4.stall_valid", out_valid, 1);
            chk("t4.stall_bin", out_binary, 0);
        end
        hs_base   = hs_cnt;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4.b_bin", out_binary, 1);
        in_gray = 4'b0011;
        @(posedge clk);
        #1;
        chk("t4.c_bin", out_binary, 2);
        in_gray = 4'b0010;
        @(posedge clk);
        #1;
        chk("t4.d_bin", out_binary, 3);
        chk("t4.d_err", out_step_err, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t4.drain_valid", out_valid, 0);
        chk("t4.handshakes", hs_cnt - hs_base, 4);

        // saturation of a 2-bit counter
        do_reset();
        send("t5s", 4'b0000, 4'd0, 0, 0, 2'd0, 0);
        send("t5e1", 4'b0011, 4'd2, 1, 2, 2'd1, 0);
        send("t5g1", 4'b0001, 4'd1, 0, 0, 2'd1, 0);
        send("t5e2", 4'b0010, 4'd3, 1, 2, 2'd2, 0);
        send("t5g2", 4'b0000, 4'd0, 0, 0, 2'd2, 0);
        send("t5e3", 4'b0011, 4'd2, 1, 2, 2'd3, 0);
        send("t5g3", 4'b0001, 4'd1, 0, 0, 2'd3, 0);
        send("t5e4", 4'b0010, 4'd3, 1, 2, 2'd3, 0);
        send("t5g4", 4'b0000, 4'd0, 0, 0, 2'd3, 0);
        send("t5e5", 4'b0011, 4'd2, 1, 2, 2'd3, 0);

        // clear with an accept, then clear alone
        clear = 1'b1;
        send("t6a", 4'b0110, 4'd4, 0, 2, 2'd0, 0);
        clear = 1'b0;
        send("t6b", 4'b0111, 4'd5, 0, 1, 2'd0, 0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("t6.idle_cnt", err_count, 0);
        send("t6c", 4'b1100, 4'd8, 0, 2, 2'd0, 0);
        send("t6d", 4'b1101, 4'd9, 0, 1, 2'd0, 0);

        // asynchronous reset mid-burst
        send("t7a", 4'b1111, 4'd10, 0, 1, 2'd0, 0);
        send("t7b", 4'b1000, 4'd15, 1, 2, 2'd1, 0);
        in_valid = 1'b1;
        in_gray  = 4'b1001;
        #3;
        rst_n = 1'b0;
        #1;
        chk("t7.valid", out_valid, 0);
        chk("t7.cnt", err_count, 0);
        chk("t7.bin", out_binary, 0);
        chk("t7.lost", sync_lost, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send("t7c", 4'b0110, 4'd4, 0, 2, 2'd0, 0);
        send("t7d", 4'b0111, 4'd5, 0, 1, 2'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
